// File: rtl/detect_head_stream.sv
// Purpose: re-emits per-anchor reg/cls word streams tagged with scale/anchor; reduced mode does class argmax + score threshold.
// Latency: raw mode 1 cycle in->out; reduced mode emits REG_CH+2 words (or drops in 1 cycle) after the last cls word.
// Backpressure: single output register; raw in_ready follows output slot availability, reduced REG/CLS always accept, EMIT holds while out_ready=0.
//
// Ports: clk/rst_n (async active-low); start + cfg_mode/cfg_thresh (latched at frame start);
//        in_data/in_valid/in_ready input word stream; out_data/out_valid/out_ready output stream
//        tagged with out_scale/out_anchor/out_last; busy while a frame runs; frame_done one-cycle end pulse.
module detect_head_stream #(
    parameter int NUM_SCALES = 3,
    parameter int PIX0       = 400,
    parameter int PIX1       = 100,
    parameter int PIX2       = 25,
    parameter int REG_CH     = 64,
    parameter int CLS_CH     = 80,
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    localparam int AW        = ((PIX0 + PIX1 + PIX2) > 1) ? $clog2(PIX0 + PIX1 + PIX2) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cfg_mode,
    input  logic [WIDTH-1:0] cfg_thresh,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_scale,
    output logic [AW-1:0]    out_anchor,
    output logic             out_last,
    output logic             busy,
    output logic             frame_done
);

    localparam int TOTAL = PIX0 + ((NUM_SCALES >= 2) ? PIX1 : 0) + ((NUM_SCALES >= 3) ? PIX2 : 0);
    localparam int CW    = $clog2(REG_CH + CLS_CH + 2);
    localparam int IW    = (CLS_CH > 1) ? $clog2(CLS_CH) : 1;
    localparam int BW    = (REG_CH > 1) ? $clog2(REG_CH) : 1;

    // Fixed-point position is only carried with the data; this guard just names an unusable setting.
    generate
        if (FRAC > WIDTH) begin : g_frac_exceeds_width
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_REG, S_CLS, S_EMIT, S_DONE} state_t;

    state_t                    state, state_nxt;
    logic                      mode_q;
    logic signed [WIDTH-1:0]   thresh_q;
    logic signed [WIDTH-1:0]   max_q;
    logic [IW-1:0]             idx_q;
    logic [CW-1:0]             ch;
    logic [AW-1:0]             anchor;
    logic [AW-1:0]             anchor_nxt;
    logic [1:0]                scale;
    logic [WIDTH-1:0]          reg_buf [REG_CH];

    logic out_free, accept, reg_end, cls_end, drop, emit_load, emit_end, anchor_end, last_anchor;
    logic [WIDTH-1:0] emit_word;

    assign out_free    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign reg_end     = (state == S_REG) && accept && (ch == CW'(REG_CH - 1));
    assign cls_end     = (state == S_CLS) && accept && (ch == CW'(CLS_CH - 1));
    assign drop        = (state == S_EMIT) && (max_q < thresh_q);
    assign emit_load   = (state == S_EMIT) && !drop && out_free;
    // EMIT word order: ch 0..REG_CH-1 buffered reg words, REG_CH = score, REG_CH+1 = class index
    assign emit_end    = (state == S_EMIT) && (drop || (out_free && (ch == CW'(REG_CH + 1))));
    assign anchor_end  = (cls_end && !mode_q) || emit_end;
    assign last_anchor = (anchor == AW'(TOTAL - 1));
    assign anchor_nxt  = anchor + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)   state_nxt = S_REG;
            S_REG:  if (reg_end) state_nxt = S_CLS;
            S_CLS:  if (cls_end) state_nxt = mode_q ? S_EMIT : (last_anchor ? S_DONE : S_REG);
            S_EMIT: if (emit_end) state_nxt = last_anchor ? S_DONE : S_REG;
            // Wait for the last output word to leave before signalling the end of the frame
            S_DONE: if (!out_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready   = ((state == S_REG) || (state == S_CLS)) && (mode_q || out_free);
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE) && !out_valid;
    end

    // Frame config, counters and argmax tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            thresh_q <= '0;
            ch       <= '0;
            anchor   <= '0;
            scale    <= '0;
            max_q    <= '0;
            idx_q    <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                mode_q   <= cfg_mode;
                thresh_q <= cfg_thresh;
                ch       <= '0;
                anchor   <= '0;
                scale    <= '0;
            end
        end else begin
            if (reg_end || cls_end || emit_end)
                ch <= '0;
            else if (accept || emit_load)
                ch <= ch + 1'b1;

            if (anchor_end && !last_anchor) begin
                anchor <= anchor_nxt;
                if (anchor_nxt == AW'(PIX0) || anchor_nxt == AW'(PIX0 + PIX1))
                    scale <= scale + 1'b1;
            end

            // First cls word seeds the max; strictly-greater keeps the lowest index on ties
            if (state == S_CLS && accept && (ch == '0 || $signed(in_data) > max_q)) begin
                max_q <= $signed(in_data);
                idx_q <= IW'(ch);
            end
        end
    end

    // Regression buffer needs no reset: every entry is rewritten before it is read
    always_ff @(posedge clk) begin
        if (state == S_REG && accept && mode_q)
            reg_buf[ch[BW-1:0]] <= in_data;
    end

    always_comb begin
        emit_word = '0;
        if (ch < CW'(REG_CH))       emit_word = reg_buf[ch[BW-1:0]];
        else if (ch == CW'(REG_CH)) emit_word = max_q;
        else                        emit_word = WIDTH'(idx_q);
    end

    // Output register: loads on a raw accept or an EMIT word, otherwise holds until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_scale  <= '0;
            out_anchor <= '0;
            out_last   <= 1'b0;
        end else if (!mode_q && accept) begin
            out_valid  <= 1'b1;
            out_data   <= in_data;
            out_scale  <= scale;
            out_anchor <= anchor;
            out_last   <= (state == S_CLS) && (ch == CW'(CLS_CH - 1));
        end else if (emit_load) begin
            out_valid  <= 1'b1;
            out_data   <= emit_word;
            out_scale  <= scale;
            out_anchor <= anchor;
            out_last   <= (ch == CW'(REG_CH + 1));
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_detect_head_stream.sv
// Bench for detect_head_stream with a small geometry (REG_CH=4, CLS_CH=3, anchors 2/1/1).
// Expected output words come from a per-anchor reference model built from the frame's input words.
module tb_detect_head_stream;

    localparam int RC = 4, CC = 3, P0 = 2, P1 = 1, P2 = 1;
    localparam int T  = P0 + P1 + P2;
    localparam int GW = RC + CC;
    localparam int NW = T * GW;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [15:0]   cfg_thresh = '0;
    logic [15:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_scale;
    logic [AW-1:0] out_anchor;
    logic          out_last;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    detect_head_stream #(
        .NUM_SCALES(3), .PIX0(P0), .PIX1(P1), .PIX2(P2),
        .REG_CH(RC), .CLS_CH(CC), .WIDTH(16), .FRAC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_scale(out_scale), .out_anchor(out_anchor), .out_last(out_last),
        .busy(busy), .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  s;
        logic [1:0]  a;
        logic        l;
    } exp_t;

    logic [15:0] fw [NW];
    exp_t        exp_q[$];

    function automatic int scale_of(input int a);
        return (a < P0) ? 0 : ((a < P0 + P1) ? 1 : 2);
    endfunction

    // Reference: raw forwards each anchor's 7 words; reduced emits reg words, best score, best index
    task automatic build_model(input logic mode, input logic signed [15:0] th);
        exp_t e;
        logic signed [15:0] best;
        int bi;
        exp_q.delete();
        for (int a = 0; a < T; a++) begin
            e.s = 2'(scale_of(a));
            e.a = AW'(a);
            if (!mode) begin
                for (int k = 0; k < GW; k++) begin
                    e.d = fw[a*GW + k];
                    e.l = (k == GW - 1);
                    exp_q.push_back(e);
                end
            end else begin
                best = $signed(fw[a*GW + RC]);
                bi = 0;
                for (int c = 1; c < CC; c++) begin
                    if ($signed(fw[a*GW + RC + c]) > best) begin
                        best = $signed(fw[a*GW + RC + c]);
                        bi = c;
                    end
                end
                if (best >= th) begin
                    e.l = 1'b0;
                    for (int k = 0; k < RC; k++) begin
                        e.d = fw[a*GW + k];
                        exp_q.push_back(e);
                    end
                    e.d = best;
                    exp_q.push_back(e);
                    e.d = 16'(bi);
                    e.l = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "/out_valid"},  out_valid,  0);
        check({tag, "/out_data"},   out_data,   0);
        check({tag, "/out_scale"},  out_scale,  0);
        check({tag, "/out_anchor"}, out_anchor, 0);
        check({tag, "/out_last"},   out_last,   0);
        check({tag, "/in_ready"},   in_ready,   0);
        check({tag, "/busy"},       busy,       0);
        check({tag, "/frame_done"}, frame_done, 0);
    endtask

    // Runs one frame from fw[]; abort_after>=0 stops once that many input words are handed over.
    task automatic run_frame(input string name, input logic mode, input logic [15:0] th,
                             input int pin, input int pout, input int abort_after,
                             output int ngroups);
        int   cyc;
        int   idx;
        int   last_hs;
        logic stall;
        exp_t held;
        exp_t want;
        logic have;
        bit   got_fd;
        bit   fin_emit;
        cyc = 0; idx = 0; last_hs = -10; stall = 1'b0; held = '0; got_fd = 0; ngroups = 0;
        build_model(mode, th);
        fin_emit = (exp_q.size() > 0) && (exp_q[exp_q.size()-1].a == AW'(T - 1));

        @(negedge clk);
        start = 1'b1; cfg_mode = mode; cfg_thresh = th;
        @(negedge clk);
        start = 1'b0;
        #1 check({name, "/busy_at_start"}, busy, 1);
        while (cyc < 3000) begin
            // Config and stray starts mid-frame must have no effect
            cfg_mode   = 1'($urandom);
            cfg_thresh = 16'($urandom);
            start      = busy && ($urandom_range(0, 9) == 0);
            in_valid   = (idx < NW) && ($urandom_range(0, 99) < pin);
            in_data    = in_valid ? fw[idx] : 16'($urandom);
            out_ready  = ($urandom_range(0, 99) < pout);
            #1;
            if (stall)
                check({name, "/stall_hold"}, {out_valid, out_data, out_scale, out_anchor, out_last}, {1'b1, held});
            if (!mode && out_valid && !out_ready)
                check({name, "/raw_in_ready_stall"}, in_ready, 0);
            if (out_valid && out_ready) begin
                have = (exp_q.size() != 0);
                want = have ? exp_q.pop_front() : '0;
                check({name, "/out_word"}, {1'b1, out_data, out_scale, out_anchor, out_last}, {have, want});
                last_hs = cyc;
                if (out_last) ngroups++;
            end
            stall = out_valid && !out_ready;
            held  = {out_data, out_scale, out_anchor, out_last};
            if (in_valid && in_ready) idx++;
            if (frame_done) begin
                got_fd = 1;
                check({name, "/words_left"}, exp_q.size(), 0);
                if (fin_emit) check({name, "/frame_done_lat"}, cyc, last_hs + 1);
                break;
            end
            if (abort_after >= 0 && idx == abort_after) break;
            @(negedge clk);
            cyc++;
        end
        if (abort_after < 0) begin
            check({name, "/frame_done_seen"}, got_fd, 1);
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0;
            #1;
            check({name, "/frame_done_pulse"}, frame_done, 0);
            check({name, "/idle_busy"}, busy, 0);
            check({name, "/idle_in_ready"}, in_ready, 0);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) fw[i] = 16'($urandom);
    endtask

    task automatic set_cls(input int a, input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
        fw[a*GW + RC]     = c0;
        fw[a*GW + RC + 1] = c1;
        fw[a*GW + RC + 2] = c2;
    endtask

    initial begin
        int ng;
        repeat (3) @(negedge clk);
        #1 reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Raw ramp at full throughput
        for (int i = 0; i < NW; i++) fw[i] = 16'(i);
        run_frame("raw_ramp", 1'b0, 16'h0000, 100, 100, -1, ng);
        check("raw_ramp/groups", ng, T);

        // Argmax with a tie between classes 1 and 2
        fill_random();
        for (int a = 0; a < T; a++) set_cls(a, 16'h0100, 16'h0300, 16'h0300);
        run_frame("red_tie", 1'b1, 16'h0000, 80, 100, -1, ng);
        check("red_tie/groups", ng, T);

        // Anchor 1 falls one LSB below threshold
        fill_random();
        for (int a = 0; a < T; a++) set_cls(a, 16'h0250, 16'h0210, 16'h0300);
        set_cls(1, 16'h0100, 16'h01FF, 16'h0000);
        run_frame("red_drop", 1'b1, 16'h0200, 80, 100, -1, ng);
        check("red_drop/groups", ng, 3);

        // Negative logits: -5, -3, -9 in Q8.8 against -4.0
        fill_random();
        for (int a = 0; a < T; a++) set_cls(a, 16'hFB00, 16'hFD00, 16'hF700);
        run_frame("red_neg", 1'b1, 16'hFC00, 80, 100, -1, ng);
        check("red_neg/groups", ng, T);

        // Random data with heavy output backpressure, both modes
        for (int f = 0; f < 8; f++) begin
            fill_random();
            run_frame((f % 2) ? "bp_red" : "bp_raw", 1'(f % 2), 16'($urandom), 70, 30, -1, ng);
        end

        // Reset mid-CLS of anchor 1, then a fresh frame from anchor 0
        fill_random();
        run_frame("rst_abort", 1'b1, 16'h8000, 100, 30, GW + RC + 1, ng);
        @(posedge clk);
        #2 rst_n = 1'b0;
        start = 1'b0; in_valid = 1'b0;
        #1 reset_checks("mid_reset");
        @(negedge clk);
        #1 reset_checks("mid_reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("after_reset", 1'b1, 16'h8000, 80, 30, -1, ng);
        check("after_reset/groups", ng, T);
        run_frame("after_reset_raw", 1'b0, 16'h0000, 80, 30, -1, ng);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
